// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined multi-cycle memory between I-cache and D-cache miss handlers.
// Block fills issue one read per cycle; returned words are steered combinationally to the owner.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_valid,
  output logic [2:0]  i_word,
  output logic [15:0] i_data,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_valid,
  output logic [2:0]  d_word,
  output logic [15:0] d_data,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam logic [2:0] S_FLUSH = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int          FW         = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(MEM_LATENCY - 1);
  localparam logic [3:0]  NWORDS     = 4'(BLOCK_WORDS);
  localparam logic [3:0]  LAST_WORD  = 4'(BLOCK_WORDS - 1);

  logic [2:0]    state;
  logic [FW-1:0] flush_cnt;
  logic [3:0]    issue_cnt;
  logic [3:0]    ret_cnt;
  logic          last_owner;
  logic          owner;
  logic [15:0]   base;

  logic          i_win;
  logic          d_win;
  logic          active;
  logic          filling;
  logic [15:0]   req_base;

  // On a tie the side that did not own memory last time wins.
  assign i_win    = i_req && (!d_req || (last_owner == OWN_D));
  assign d_win    = d_req && (!i_req || (last_owner == OWN_I));
  assign req_base = (d_win ? d_addr : i_addr) & 16'hFFF0;

  assign active  = (state == S_FILL) || (state == S_WRITE) || (state == S_DONE);
  assign filling = (state == S_FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FLUSH;
      flush_cnt  <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      last_owner <= OWN_I;
      owner      <= OWN_I;
      base       <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        // Absorbs returns still in flight from before reset.
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) state <= S_IDLE;
          else                         flush_cnt <= flush_cnt + 1'b1;
        end
        S_IDLE: begin
          if (i_win || d_win) begin
            owner      <= d_win;
            last_owner <= d_win;
            ret_cnt    <= '0;
            mem_en     <= 1'b1;
            if (d_win && d_wr) begin
              state     <= S_WRITE;
              mem_wr    <= 1'b1;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              issue_cnt <= '0;
            end else begin
              state     <= S_FILL;
              mem_wr    <= 1'b0;
              base      <= req_base;
              mem_addr  <= req_base;
              issue_cnt <= 4'd1;
            end
          end
        end
        S_FILL: begin
          if (issue_cnt < NWORDS) begin
            mem_en    <= 1'b1;
            mem_addr  <= base | {12'd0, issue_cnt[2:0], 1'b0};
            issue_cnt <= issue_cnt + 1'b1;
          end else begin
            mem_en <= 1'b0;
          end
          if (mem_rvalid) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (ret_cnt == LAST_WORD) state <= S_DONE;
          end
        end
        S_WRITE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_FLUSH;
      endcase
    end
  end

  assign i_grant = active && (owner == OWN_I);
  assign d_grant = active && (owner == OWN_D);
  assign i_valid = filling && (owner == OWN_I) && mem_rvalid;
  assign d_valid = filling && (owner == OWN_D) && mem_rvalid;
  assign i_done  = (state == S_DONE) && (owner == OWN_I);
  assign d_done  = (state == S_DONE) && (owner == OWN_D);
  assign i_word  = ret_cnt[2:0];
  assign d_word  = ret_cnt[2:0];
  assign i_data  = mem_rdata;
  assign d_data  = mem_rdata;

endmodule
